// File: rtl/contador_updown_param.sv
// Parametrised up/down/bounce counter with runtime limits, synchronous load,
// registered wrap/turn event pulses and a limit-error flag.
module contador_updown_param #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo_limit,
  input  logic [WIDTH-1:0] hi_limit,
  output logic [WIDTH-1:0] cont,
  output logic             dir,
  output logic             wrap,
  output logic             turn,
  output logic             limit_err
);

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  logic [WIDTH-1:0] cont_q, cont_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             turn_q, turn_d;
  logic             limit_err_q, limit_err_d;

  logic             eff_up;
  logic             in_range;
  logic             at_hi;
  logic             at_lo;
  logic             single_point;

  always_comb begin
    eff_up       = (mode == MODE_UP) ? 1'b1 : ((mode == MODE_DOWN) ? 1'b0 : dir_q);
    in_range     = (cont_q >= lo_limit) && (cont_q <= hi_limit);
    at_hi        = (cont_q == hi_limit);
    at_lo        = (cont_q == lo_limit);
    single_point = (lo_limit == hi_limit);
  end

  // Priority: load, then an inverted limit window, then enable/mode.
  always_comb begin
    cont_d      = cont_q;
    dir_d       = dir_q;
    wrap_d      = 1'b0;
    turn_d      = 1'b0;
    limit_err_d = (lo_limit > hi_limit);

    if (load) begin
      cont_d = load_value;
    end else if (limit_err_d || !enable || (mode == MODE_HOLD)) begin
      cont_d = cont_q;
    end else if (!in_range || single_point) begin
      // Snap back into the window from the side we are travelling towards.
      cont_d = eff_up ? lo_limit : hi_limit;
      dir_d  = eff_up;
    end else begin
      case (mode)
        MODE_UP: begin
          dir_d = 1'b1;
          if (at_hi) begin
            cont_d = lo_limit;
            wrap_d = 1'b1;
          end else begin
            cont_d = cont_q + 1'b1;
          end
        end
        MODE_DOWN: begin
          dir_d = 1'b0;
          if (at_lo) begin
            cont_d = hi_limit;
            wrap_d = 1'b1;
          end else begin
            cont_d = cont_q - 1'b1;
          end
        end
        MODE_BOUNCE: begin
          if (dir_q) begin
            if (at_hi) begin
              cont_d = hi_limit - 1'b1;
              dir_d  = 1'b0;
              turn_d = 1'b1;
            end else begin
              cont_d = cont_q + 1'b1;
            end
          end else begin
            if (at_lo) begin
              cont_d = lo_limit + 1'b1;
              dir_d  = 1'b1;
              turn_d = 1'b1;
            end else begin
              cont_d = cont_q - 1'b1;
            end
          end
        end
        default: begin
          cont_d = cont_q;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cont_q      <= RESET_VAL;
      dir_q       <= 1'b1;
      wrap_q      <= 1'b0;
      turn_q      <= 1'b0;
      limit_err_q <= 1'b0;
    end else begin
      cont_q      <= cont_d;
      dir_q       <= dir_d;
      wrap_q      <= wrap_d;
      turn_q      <= turn_d;
      limit_err_q <= limit_err_d;
    end
  end

  assign cont      = cont_q;
  assign dir       = dir_q;
  assign wrap      = wrap_q;
  assign turn      = turn_q;
  assign limit_err = limit_err_q;

endmodule

// File: tb/tb_contador_updown_param.sv
// Bench for contador_updown_param: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural reference model.
module tb_contador_updown_param;

  localparam int W = 4;

  logic         clock;
  logic         reset;
  logic         enable;
  logic         load;
  logic [W-1:0] loadValue;
  logic [1:0]   mode;
  logic [W-1:0] loLimit;
  logic [W-1:0] hiLimit;
  logic [W-1:0] cont;
  logic         dir;
  logic         wrap;
  logic         turn;
  logic         limitErr;

  int checks = 0;
  int errors = 0;
  bit compareOn = 0;

  int mCont;
  int mDir;
  int mWrap;
  int mTurn;
  int mErr;
  int lo, hi, c, up;

  contador_updown_param #(.WIDTH(W), .RESET_VAL(4'd0)) dut (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .load_value(loadValue), .mode(mode), .lo_limit(loLimit), .hi_limit(hiLimit),
    .cont(cont), .dir(dir), .wrap(wrap), .turn(turn), .limit_err(limitErr)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  // Reference model: plain integer arithmetic on the counting rules
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mCont = 0; mDir = 1; mWrap = 0; mTurn = 0; mErr = 0;
    end else begin
      lo = loLimit; hi = hiLimit; c = mCont;
      mWrap = 0; mTurn = 0;
      mErr = (lo > hi) ? 1 : 0;
      if (load) mCont = loadValue;
      else if (lo <= hi && enable && mode != 2'd3) begin
        up = (mode == 2'd0) ? 1 : (mode == 2'd1) ? 0 : mDir;
        if (c < lo || c > hi || lo == hi) mCont = up ? lo : hi;
        else if (up == 1) begin
          if (c < hi) mCont = c + 1;
          else if (mode == 2'd2) begin mCont = hi - 1; mTurn = 1; up = 0; end
          else begin mCont = lo; mWrap = 1; end
        end else begin
          if (c > lo) mCont = c - 1;
          else if (mode == 2'd2) begin mCont = lo + 1; mTurn = 1; up = 1; end
          else begin mCont = hi; mWrap = 1; end
        end
        mDir = up;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clock) begin
    if (compareOn) begin
      checkOutput("model_cont", int'(cont), mCont);
      checkOutput("model_dir", int'(dir), mDir);
      checkOutput("model_wrap", int'(wrap), mWrap);
      checkOutput("model_turn", int'(turn), mTurn);
      checkOutput("model_limit_err", int'(limitErr), mErr);
    end
  end

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic applyStimulus(input bit en, input bit ld, input int lv,
                               input int md, input int l, input int h);
    enable    = en;
    load      = ld;
    loadValue = W'(lv);
    mode      = 2'(md);
    loLimit   = W'(l);
    hiLimit   = W'(h);
  endtask

  initial begin
    int a, b;
    reset = 0;
    applyStimulus(0, 0, 0, 2, 0, 15);
    @(negedge clock);
    @(negedge clock);
    checkOutput("reset_cont", int'(cont), 0);
    checkOutput("reset_dir", int'(dir), 1);
    checkOutput("reset_pulses", int'({wrap, turn, limitErr}), 0);
    compareOn = 1;

    // Full-range bounce from reset: 0..15..0..1
    reset = 1;
    applyStimulus(1, 0, 0, 2, 0, 15);
    for (int k = 1; k <= 31; k++) begin
      step();
      if (k == 15) checkOutput("t1_top", int'(cont), 15);
      if (k == 16) begin
        checkOutput("t1_turn_top_cont", int'(cont), 14);
        checkOutput("t1_turn_top", int'(turn), 1);
      end
      if (k == 30) checkOutput("t1_bottom", int'(cont), 0);
      if (k == 31) begin
        checkOutput("t1_turn_bottom_cont", int'(cont), 1);
        checkOutput("t1_turn_bottom", int'(turn), 1);
      end
    end

    // Up-wrap then down-wrap inside [3,6]
    applyStimulus(1, 1, 3, 0, 3, 6);
    step();
    checkOutput("t2_load", int'(cont), 3);
    load = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 3) checkOutput("t2_no_wrap", int'(wrap), 0);
    end
    checkOutput("t2_wrap_cont", int'(cont), 3);
    checkOutput("t2_wrap", int'(wrap), 1);
    mode = 2'd1;
    step();
    checkOutput("t2_down_wrap_cont", int'(cont), 6);
    checkOutput("t2_down_wrap", int'(wrap), 1);
    for (int k = 1; k <= 4; k++) step();
    checkOutput("t2_down_wrap2_cont", int'(cont), 6);

    // Load outside the window, then snap to lo without a wrap
    applyStimulus(1, 1, 5, 0, 3, 9);
    step();
    applyStimulus(1, 1, 12, 0, 3, 9);
    step();
    checkOutput("t3_load12", int'(cont), 12);
    load = 0;
    step();
    checkOutput("t3_snap_lo", int'(cont), 3);
    checkOutput("t3_no_wrap", int'(wrap), 0);

    // Degenerate and inverted windows
    applyStimulus(1, 0, 0, 0, 7, 7);
    step();
    step();
    checkOutput("t4_single", int'(cont), 7);
    applyStimulus(1, 0, 0, 0, 9, 4);
    step();
    checkOutput("t4_limit_err", int'(limitErr), 1);
    checkOutput("t4_frozen", int'(cont), 7);
    applyStimulus(1, 0, 0, 0, 0, 15);
    step();
    checkOutput("t4_err_clear", int'(limitErr), 0);

    // Asynchronous reset between edges at cont=11, dir=0
    applyStimulus(1, 1, 12, 1, 0, 15);
    step();
    load = 0;
    step();
    checkOutput("t5_pre_cont", int'(cont), 11);
    checkOutput("t5_pre_dir", int'(dir), 0);
    #2 reset = 0;
    #1;
    checkOutput("t5_async_cont", int'(cont), 0);
    checkOutput("t5_async_dir", int'(dir), 1);
    @(negedge clock);
    reset = 1;
    mode = 2'd0;
    step();
    checkOutput("t5_resume", int'(cont), 1);

    // Bounce with enable toggling every cycle in [2,5]
    applyStimulus(1, 1, 2, 2, 2, 5);
    step();
    load = 0;
    for (int k = 0; k < 24; k++) begin
      enable = ~enable;
      step();
    end

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      enable = ($urandom_range(0, 7) != 0);
      load = ($urandom_range(0, 19) == 0);
      loadValue = W'($urandom);
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        a = $urandom_range(0, 15);
        b = $urandom_range(0, 15);
        if ($urandom_range(0, 3) != 0 && a > b) begin
          loLimit = W'(b); hiLimit = W'(a);
        end else begin
          loLimit = W'(a); hiLimit = W'(b);
        end
      end
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 0;
        #1;
        checkOutput("rand_async_cont", int'(cont), 0);
        #1 reset = 1;
      end
      step();
    end

    compareOn = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
